// File: rtl/led_pattern_gen.sv
// led_pattern_gen: run-time selectable LED pattern sequencer with prescaler.
// Build option: define LEDPAT_GAP_EN to insert an all-zero gap frame per wrap.
//
// Ports:
//   clk  - system clock, rising edge
//   rs   - asynchronous active-low reset
//   en   - 1 = run, 0 = freeze frame, prescaler and travel flag
//   mode - 0 SHIFT_OFF, 1 FILL_ON, 2 BOUNCE, 3 BLINK
//   dir  - 0 = shift toward MSB, 1 = shift toward LSB
//   div  - step period minus one, in clk cycles
//   led  - current frame (registered)
//   step - one-cycle pulse on every frame advance
//   wrap - one-cycle pulse when the pattern completes a cycle
module led_pattern_gen #(
    parameter int WIDTH = 8,
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             rs,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             dir,
    input  logic [DIV_W-1:0] div,
    output logic [WIDTH-1:0] led,
    output logic             step,
    output logic             wrap
);

    localparam logic [1:0] M_SHIFT_OFF = 2'd0;
    localparam logic [1:0] M_FILL_ON   = 2'd1;
    localparam logic [1:0] M_BOUNCE    = 2'd2;
    localparam logic [1:0] M_BLINK     = 2'd3;

    localparam logic [WIDTH-1:0] ONES  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZEROS = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] LSB1  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MSB1  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [DIV_W-1:0] CNT_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

    logic [1:0]       mode_q, mode_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] led_q, led_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             travel_q, travel_d;
    logic             gap_q, gap_d;
    logic             step_q, step_d;
    logic             wrap_q, wrap_d;

    logic             cfg_chg;
    logic             tick;
    logic [WIDTH-1:0] init_f;
    logic [WIDTH-1:0] new_init_f;
    logic [WIDTH-1:0] shl0, shr0, shl1, shr1;
    logic [WIDTH-1:0] adv_led;
    logic             adv_travel;
    logic             adv_gap;
    logic             adv_wrap;
    logic             wrap_hit;

    function automatic logic [WIDTH-1:0] init_frame(
        input logic [1:0] m,
        input logic       d
    );
        logic [WIDTH-1:0] f;
        f = ONES;
        unique case (m)
            M_SHIFT_OFF: f = ONES;
            M_FILL_ON:   f = ZEROS;
            M_BOUNCE:    f = d ? MSB1 : LSB1;
            M_BLINK:     f = ONES;
        endcase
        return f;
    endfunction

    assign cfg_chg    = (mode != mode_q) || (dir != dir_q);
    // >= rather than == so a div shrunk below the running count fires now
    assign tick       = en && (cnt_q >= div);
    assign init_f     = init_frame(mode_q, dir_q);
    assign new_init_f = init_frame(mode, dir);

    assign shl0 = {led_q[WIDTH-2:0], 1'b0};
    assign shr0 = {1'b0, led_q[WIDTH-1:1]};
    assign shl1 = {led_q[WIDTH-2:0], 1'b1};
    assign shr1 = {1'b1, led_q[WIDTH-1:1]};

    // Next frame of the latched pattern, used only on a prescaler tick.
    always_comb begin
        adv_led    = led_q;
        adv_travel = travel_q;
        adv_gap    = 1'b0;
        adv_wrap   = 1'b0;
        wrap_hit   = 1'b0;
        if (gap_q) begin
            adv_led    = init_f;
            adv_travel = dir_q;
        end else begin
            unique case (mode_q)
                M_SHIFT_OFF: begin
                    if (led_q == ZEROS) wrap_hit = 1'b1;
                    else adv_led = dir_q ? shr0 : shl0;
                end
                M_FILL_ON: begin
                    if (led_q == ONES) wrap_hit = 1'b1;
                    else adv_led = dir_q ? shr1 : shl1;
                end
                M_BOUNCE: begin
                    // travel_q: 0 = moving toward MSB, 1 = toward LSB;
                    // flips on arrival at an end so no frame repeats
                    if (!travel_q) begin
                        adv_led = shl0;
                        if (shl0[WIDTH-1]) adv_travel = 1'b1;
                    end else begin
                        adv_led = shr0;
                        if (shr0[0]) adv_travel = 1'b0;
                    end
                    if (adv_led == init_f) wrap_hit = 1'b1;
                end
                M_BLINK: begin
                    if (led_q == ZEROS) wrap_hit = 1'b1;
                    else adv_led = ZEROS;
                end
            endcase
            if (wrap_hit) begin
                adv_wrap = 1'b1;
`ifdef LEDPAT_GAP_EN
                adv_led  = ZEROS;
                adv_gap  = 1'b1;
`else
                adv_led    = init_f;
                adv_travel = dir_q;
`endif
            end
        end
    end

    always_comb begin
        mode_d   = mode_q;
        dir_d    = dir_q;
        led_d    = led_q;
        cnt_d    = cnt_q;
        travel_d = travel_q;
        gap_d    = gap_q;
        step_d   = 1'b0;
        wrap_d   = 1'b0;
        if (cfg_chg) begin
            // A config change overrides any coincident tick.
            mode_d   = mode;
            dir_d    = dir;
            led_d    = new_init_f;
            cnt_d    = '0;
            travel_d = dir;
            gap_d    = 1'b0;
        end else if (en) begin
            if (tick) begin
                cnt_d    = '0;
                led_d    = adv_led;
                travel_d = adv_travel;
                gap_d    = adv_gap;
                step_d   = 1'b1;
                wrap_d   = adv_wrap;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rs) begin
        if (!rs) begin
            mode_q   <= M_SHIFT_OFF;
            dir_q    <= 1'b0;
            led_q    <= ONES;
            cnt_q    <= '0;
            travel_q <= 1'b0;
            gap_q    <= 1'b0;
            step_q   <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            dir_q    <= dir_d;
            led_q    <= led_d;
            cnt_q    <= cnt_d;
            travel_q <= travel_d;
            gap_q    <= gap_d;
            step_q   <= step_d;
            wrap_q   <= wrap_d;
        end
    end

    assign led  = led_q;
    assign step = step_q;
    assign wrap = wrap_q;

endmodule
